// File: rtl/io_port_bank_if.sv
// Core/board-facing signal bundle for io_port_bank.
// The master side drives requests and board inputs; the slave side is the bank itself.
interface io_port_bank_if #(
  parameter int DATA_W  = 32,
  parameter int SW_W    = 13,
  parameter int NUM_OUT = 4,
  parameter int ADDR_W  = 2
);
  logic [SW_W-1:0]           Switches;
  logic                      Set;
  logic                      InReq;
  logic                      OutWe;
  logic [ADDR_W-1:0]         Addr;
  logic [DATA_W-1:0]         WrData;
  logic [DATA_W-1:0]         DataIO;
  logic                      InValid;
  logic                      Wait;
  logic [DATA_W-1:0]         Output;
  logic [NUM_OUT*DATA_W-1:0] OutBus;
  logic                      AddrErr;

  modport master (
    output Switches, Set, InReq, OutWe, Addr, WrData,
    input  DataIO, InValid, Wait, Output, OutBus, AddrErr
  );

  modport slave (
    input  Switches, Set, InReq, OutWe, Addr, WrData,
    output DataIO, InValid, Wait, Output, OutBus, AddrErr
  );
endinterface

// File: rtl/io_port_bank.sv
// Memory-mapped I/O bank: NUM_OUT writable output registers plus a debounced,
// handshaked switch-input channel that stalls the core until the operator presses Set.
module io_port_bank #(
  parameter int DATA_W       = 32,
  parameter int SW_W         = 13,
  parameter int NUM_OUT      = 4,
  parameter int ADDR_W       = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic          Clock,
  input  logic          Reset,
  io_port_bank_if.slave bus
);

  localparam int                CNT_W     = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [ADDR_W:0]   NUM_OUT_A = (ADDR_W + 1)'(NUM_OUT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE
  } state_e;

  logic [SYNC_STAGES-1:0]    sync_q;
  logic                      synced;
  logic                      deb_q, deb_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  state_e                    state_q, state_d;
  logic                      consumed_q, consumed_d;
  logic                      wait_q, wait_d;
  logic                      valid_q, valid_d;
  logic [DATA_W-1:0]         data_q, data_d;

  logic [DATA_W-1:0]         output_q;
  logic                      addr_err_q;
  logic [NUM_OUT*DATA_W-1:0] out_bus;
  logic                      addr_ok;
  logic                      wr_req;
  logic                      wr_en;

  // Set is asynchronous to Clock; only the last stage is used downstream.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.Set};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Any cycle where synced agrees with the debounced level restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (synced != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    consumed_d = consumed_q;
    valid_d    = 1'b0;
    data_d     = data_q;
    case (state_q)
      IDLE: begin
        // A button already down when the request arrives is stale: wait for release first.
        if (bus.InReq) begin
          state_d = deb_q ? WAIT_RELEASE : WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        if (deb_q) begin
          data_d     = DATA_W'(bus.Switches);
          valid_d    = 1'b1;
          consumed_d = 1'b1;
          state_d    = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!deb_q) begin
          consumed_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    wait_d = (state_d == WAIT_PRESS) ||
             ((state_d == WAIT_RELEASE) && bus.InReq && !consumed_d);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      consumed_q <= 1'b0;
      wait_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      consumed_q <= consumed_d;
      wait_q     <= wait_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
    end
  end

  // Writes presented while the core is stalled are dropped silently.
  assign addr_ok = ({1'b0, bus.Addr} < NUM_OUT_A);
  assign wr_req  = bus.OutWe && !wait_q;
  assign wr_en   = wr_req && addr_ok;

  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out_reg
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
    logic [DATA_W-1:0] reg_q;

    always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
        reg_q <= '0;
      end else if (wr_en && (bus.Addr == IDX)) begin
        reg_q <= bus.WrData;
      end
    end

    assign out_bus[gi*DATA_W +: DATA_W] = reg_q;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      output_q   <= '0;
      addr_err_q <= 1'b0;
    end else begin
      if (wr_en) begin
        output_q <= bus.WrData;
      end
      if (wr_req && !addr_ok) begin
        addr_err_q <= 1'b1;
      end
    end
  end

  assign bus.DataIO  = data_q;
  assign bus.InValid = valid_q;
  assign bus.Wait    = wait_q;
  assign bus.Output  = output_q;
  assign bus.OutBus  = out_bus;
  assign bus.AddrErr = addr_err_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Self-checking bench for io_port_bank: register writes, address errors and the
// debounced Set handshake, with captured switch values checked through a scoreboard.
module tb_io_port_bank;

  localparam int DATA_W  = 32;
  localparam int SW_W    = 13;
  localparam int NUM_OUT = 3;
  localparam int ADDR_W  = 2;
  localparam int SYNC    = 2;
  localparam int DEB     = 4;
  localparam int LAT     = SYNC + DEB + 1;

  logic Clock;
  logic Reset;

  io_port_bank_if #(
    .DATA_W (DATA_W),
    .SW_W   (SW_W),
    .NUM_OUT(NUM_OUT),
    .ADDR_W (ADDR_W)
  ) bus_if ();

  io_port_bank #(
    .DATA_W      (DATA_W),
    .SW_W        (SW_W),
    .NUM_OUT     (NUM_OUT),
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (SYNC),
    .DEBOUNCE_CYC(DEB)
  ) u_dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus_if.slave)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int pulse_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_regs[NUM_OUT];
  logic [DATA_W-1:0] exp_out;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic wait_valid(input int budget, output int k_found);
    k_found = 0;
    for (int k = 1; k <= budget; k++) begin
      tick(1);
      if (bus_if.InValid === 1'b1) begin
        k_found = k;
        break;
      end
    end
  endtask

  function automatic logic [127:0] exp_bus();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < NUM_OUT; i++) v[i*DATA_W +: DATA_W] = exp_regs[i];
    return v;
  endfunction

  task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus_if.OutWe  = 1'b1;
    bus_if.Addr   = a;
    bus_if.WrData = d;
    tick(1);
    bus_if.OutWe  = 1'b0;
  endtask

  // Scoreboard side: every InValid pulse must match the oldest pending capture.
  always @(posedge Clock) begin
    #1;
    if (bus_if.InValid === 1'b1) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_invalid", 1, 0);
      end else begin
        check_eq("dataio", bus_if.DataIO, exp_q.pop_front());
      end
      check_eq("wait_low_at_valid", bus_if.Wait, 0);
    end
  end

  initial begin
    int found;
    int pulses0;

    bus_if.Switches = '0;
    bus_if.Set      = 1'b0;
    bus_if.InReq    = 1'b0;
    bus_if.OutWe    = 1'b0;
    bus_if.Addr     = '0;
    bus_if.WrData   = '0;
    for (int i = 0; i < NUM_OUT; i++) exp_regs[i] = '0;
    exp_out = '0;
    Reset = 1'b0;
    tick(2);
    check_eq("rst_wait", bus_if.Wait, 0);
    check_eq("rst_dataio", bus_if.DataIO, 0);
    check_eq("rst_outbus", bus_if.OutBus, 0);
    check_eq("rst_addrerr", bus_if.AddrErr, 0);
    Reset = 1'b1;
    tick(1);

    // T1: single write, then fill the other registers
    write_reg(2'd2, 32'hCAFE0001);
    exp_regs[2] = 32'hCAFE0001; exp_out = 32'hCAFE0001;
    check_eq("t1_reg2", bus_if.OutBus[95:64], 32'hCAFE0001);
    check_eq("t1_output", bus_if.Output, exp_out);
    check_eq("t1_others", bus_if.OutBus[63:0], 0);
    write_reg(2'd0, 32'h11111111);
    exp_regs[0] = 32'h11111111;
    write_reg(2'd1, 32'h22222222);
    exp_regs[1] = 32'h22222222; exp_out = 32'h22222222;
    check_eq("t1_outbus_all", bus_if.OutBus, exp_bus());
    check_eq("t1_output_last", bus_if.Output, exp_out);

    // T2: out-of-range address
    write_reg(2'd3, 32'hDEADBEEF);
    check_eq("t2_outbus", bus_if.OutBus, exp_bus());
    check_eq("t2_output", bus_if.Output, exp_out);
    check_eq("t2_addrerr", bus_if.AddrErr, 1);
    tick(3);
    check_eq("t2_addrerr_sticky", bus_if.AddrErr, 1);

    // T3: clean press held 10 cycles
    pulses0 = pulse_cnt;
    bus_if.Switches = 13'h1ABC;
    bus_if.InReq = 1'b1;
    tick(1);
    check_eq("t3_wait_rise", bus_if.Wait, 1);
    exp_q.push_back(32'h00001ABC);
    bus_if.Set = 1'b1;
    wait_valid(20, found);
    check_eq("t3_latency", found, LAT);
    bus_if.InReq = 1'b0;
    tick(3);
    bus_if.Set = 1'b0;
    tick(10);
    check_eq("t3_one_pulse", pulse_cnt - pulses0, 1);
    check_eq("t3_dataio_hold", bus_if.DataIO, 32'h00001ABC);

    // T4: bouncing Set, InReq held through the whole press
    pulses0 = pulse_cnt;
    bus_if.Switches = 13'h0555;
    bus_if.InReq = 1'b1;
    tick(1);
    exp_q.push_back(32'h00000555);
    for (int b = 0; b < 4; b++) begin
      bus_if.Set = ~b[0];
      tick(2);
    end
    check_eq("t4_no_pulse_bounce", pulse_cnt - pulses0, 0);
    check_eq("t4_wait_bounce", bus_if.Wait, 1);
    bus_if.Set = 1'b1;
    wait_valid(20, found);
    check_eq("t4_latency", found, LAT);
    tick(12);
    check_eq("t4_wait_after", bus_if.Wait, 0);
    check_eq("t4_one_pulse", pulse_cnt - pulses0, 1);
    bus_if.InReq = 1'b0;
    bus_if.Set = 1'b0;
    tick(12);

    // T5: stale press when the request arrives
    pulses0 = pulse_cnt;
    bus_if.Set = 1'b1;
    tick(10);
    bus_if.Switches = 13'h0F0F;
    bus_if.InReq = 1'b1;
    tick(1);
    check_eq("t5_wait_rise", bus_if.Wait, 1);
    tick(5);
    check_eq("t5_wait_held", bus_if.Wait, 1);
    check_eq("t5_no_capture", pulse_cnt - pulses0, 0);
    bus_if.Set = 1'b0;
    tick(LAT + 1);
    check_eq("t5_wait_press", bus_if.Wait, 1);
    check_eq("t5_no_capture_rel", pulse_cnt - pulses0, 0);
    exp_q.push_back(32'h00000F0F);
    bus_if.Set = 1'b1;
    wait_valid(20, found);
    check_eq("t5_latency", found, LAT);
    bus_if.InReq = 1'b0;
    bus_if.Set = 1'b0;
    tick(12);

    // T6: write alongside request, blocked write, then reset mid-wait
    bus_if.Switches = 13'h1234;
    bus_if.InReq = 1'b1;
    write_reg(2'd1, 32'h33333333);
    exp_regs[1] = 32'h33333333; exp_out = 32'h33333333;
    check_eq("t6_simul_write", bus_if.OutBus, exp_bus());
    check_eq("t6_wait", bus_if.Wait, 1);
    write_reg(2'd0, 32'h0BADF00D);
    check_eq("t6_blocked_bus", bus_if.OutBus, exp_bus());
    check_eq("t6_blocked_out", bus_if.Output, exp_out);
    pulses0 = pulse_cnt;
    Reset = 1'b0;
    #1;
    check_eq("t6_rst_wait", bus_if.Wait, 0);
    check_eq("t6_rst_dataio", bus_if.DataIO, 0);
    check_eq("t6_rst_outbus", bus_if.OutBus, 0);
    check_eq("t6_rst_addrerr", bus_if.AddrErr, 0);
    for (int i = 0; i < NUM_OUT; i++) exp_regs[i] = '0;
    bus_if.InReq = 1'b0;
    tick(2);
    Reset = 1'b1;
    tick(10);
    check_eq("t6_post_wait", bus_if.Wait, 0);
    check_eq("t6_post_dataio", bus_if.DataIO, 0);
    check_eq("t6_no_pulse", pulse_cnt - pulses0, 0);

    // Fresh handshake confirms the FSM and debouncer restarted cleanly
    bus_if.Switches = 13'h0777;
    bus_if.InReq = 1'b1;
    tick(1);
    check_eq("t6_wait_again", bus_if.Wait, 1);
    exp_q.push_back(32'h00000777);
    bus_if.Set = 1'b1;
    wait_valid(20, found);
    check_eq("t6_latency", found, LAT);
    bus_if.InReq = 1'b0;
    bus_if.Set = 1'b0;
    tick(12);

    check_eq("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
